seq_detect_prog: RTL and testbench

Programmable, parametrised serial sequence detector. It is the next generation of the fixed-pattern detectors: pattern width is set by a parameter, and the pattern, per-bit don't-care mask and overlap mode are loaded at run time. It also adds a serial-valid qualifier and an optional saturating match counter. It sits on a 1-bit serial stream and raises a one-cycle `flag` per detected occurrence.

---
 rtl/seq_detect_pkg.sv | 15 +
 rtl/seq_detect_if.sv | 34 +++
 rtl/seq_detect_match_cnt.sv | 26 ++
 rtl/seq_detect_prog.sv | 102 ++++++++++
 tb/tb_seq_detect_prog.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared types and defaults for the programmable sequence detector
// Purpose: detector state encoding and default parameter values.
// Contents: state_t (IDLE, FILL, RUN), DEFAULT_WIDTH, DEFAULT_CNT_W.
package seq_detect_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_detect_if.sv
// rtl/seq_detect_if.sv - stream/config/status bundle for the programmable sequence detector
// Purpose: groups the serial stream, run-time config and status signals.
// Signals: din, din_vld (serial stream); cfg_load, pattern, mask, overlap (config);
//          cnt_clr (counter clear); flag, armed, match_cnt (status).
// Modports: master drives stream/config and observes status; slave is the detector.
interface seq_detect_if
  import seq_detect_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  logic             din;
  logic             din_vld;
  logic             cfg_load;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] mask;
  logic             overlap;
  logic             cnt_clr;
  logic             flag;
  logic             armed;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output din, din_vld, cfg_load, pattern, mask, overlap, cnt_clr,
    input  flag, armed, match_cnt
  );

  modport slave (
    input  din, din_vld, cfg_load, pattern, mask, overlap, cnt_clr,
    output flag, armed, match_cnt
  );

endinterface

// File: rtl/seq_detect_match_cnt.sv
// rtl/seq_detect_match_cnt.sv - saturating match counter with clear priority
// Purpose: counts match pulses, sticks at all-ones, clr beats inc on the same edge.
// Ports: clk, rst_n (async active-low), clr, inc, cnt[CNT_W-1:0].
module seq_detect_match_cnt
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial sequence detector with mask and overlap control
// Purpose: shifts a qualified 1-bit stream and pulses flag one cycle after each
//          occurrence of the loaded pattern (masked bits are don't-care).
// Ports: clk, rst_n (async active-low), bus (seq_detect_if.slave: din, din_vld,
//        cfg_load, pattern, mask, overlap, cnt_clr in; flag, armed, match_cnt out).
// Build option: SEQ_DETECT_CNT_EN adds the saturating match counter; without it
//               match_cnt is tied to zero and cnt_clr is ignored.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_detect_if.slave  bus
);

  localparam int             FW        = $clog2(WIDTH + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] cfg_pattern;
  logic [WIDTH-1:0] cfg_mask;
  logic             cfg_overlap;
  logic [FW-1:0]    fill;
  logic             flag_q;
  logic             armed_q;

  logic [WIDTH-1:0] next_sr;
  logic [FW-1:0]    next_fill;
  logic             hit;

  assign next_sr   = {sr[WIDTH-2:0], bus.din};
  assign next_fill = (fill == FILL_FULL) ? fill : fill + 1'b1;

  // A match needs a full window after this bit; cfg_load on the same edge
  // restarts detection, so it suppresses the match.
  assign hit = (state != IDLE) && bus.din_vld && !bus.cfg_load &&
               (next_fill == FILL_FULL) &&
               (((next_sr ^ cfg_pattern) & cfg_mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sr          <= '0;
      fill        <= '0;
      cfg_pattern <= '0;
      cfg_mask    <= '0;
      cfg_overlap <= 1'b0;
      flag_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      flag_q <= hit;
      if (bus.cfg_load) begin
        cfg_pattern <= bus.pattern;
        cfg_mask    <= bus.mask;
        cfg_overlap <= bus.overlap;
        sr          <= '0;
        fill        <= '0;
        state       <= FILL;
        armed_q     <= 1'b0;
      end else if (bus.din_vld && (state != IDLE)) begin
        if (hit && !cfg_overlap) begin
          // Non-overlapping: the matched bits cannot seed the next match.
          sr      <= '0;
          fill    <= '0;
          state   <= FILL;
          armed_q <= 1'b0;
        end else begin
          sr   <= next_sr;
          fill <= next_fill;
          if (next_fill == FILL_FULL) begin
            state   <= RUN;
            armed_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.flag  = flag_q;
  assign bus.armed = armed_q;

`ifdef SEQ_DETECT_CNT_EN
  seq_detect_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.cnt_clr),
    .inc   (hit),
    .cnt   (bus.match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.match_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - self-checking bench for seq_detect_prog
module tb_seq_detect_prog;

  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_detect_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  seq_detect_prog #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit           din;
    bit           vld;
    bit           load;
    logic [W-1:0] pat;
    logic [W-1:0] msk;
    bit           ov;
    bit           clr;
    bit           flag;
    bit           armed;
    int           cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic int ecnt(input int c);
    return CNT_EN ? c : 0;
  endfunction

  function automatic void add(input bit d, v, ld, input logic [W-1:0] p, m,
                              input bit ov, clr, f, a, input int c);
    vec_t t;
    t.din = d; t.vld = v; t.load = ld; t.pat = p; t.msk = m; t.ov = ov; t.clr = clr;
    t.flag = f; t.armed = a; t.cnt = c;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check3(input string tag, input bit f, input bit a, input int c);
    check({tag, ".flag"},  int'(bus.flag),      int'(f));
    check({tag, ".armed"}, int'(bus.armed),     int'(a));
    check({tag, ".cnt"},   int'(bus.match_cnt), ecnt(c));
  endtask

  task automatic drive(input bit d, v, ld, input logic [W-1:0] p, m, input bit ov, clr);
    bus.din = d; bus.din_vld = v; bus.cfg_load = ld;
    bus.pattern = p; bus.mask = m; bus.overlap = ov; bus.cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input bit d, v, ld, input logic [W-1:0] p, m,
                      input bit ov, clr, f, a, input int c);
    drive(d, v, ld, p, m, ov, clr);
    check3(tag, f, a, c);
  endtask

  // Reference model: keeps the valid bits seen since the last restart and
  // compares the newest W of them against the pattern in time order.
  bit           m_loaded;
  bit           m_hist[$];
  logic [W-1:0] m_pat, m_msk;
  bit           m_ov;
  int           m_cnt;
  bit           e_flag, e_armed;

  task automatic model_reset();
    m_loaded = 0; m_hist.delete(); m_cnt = 0; m_pat = '0; m_msk = '0; m_ov = 0;
  endtask

  task automatic model_step(input bit d, v, ld, input logic [W-1:0] p, m, input bit ov, clr);
    bit ok;
    e_flag = 0;
    if (ld) begin
      m_loaded = 1; m_pat = p; m_msk = m; m_ov = ov; m_hist.delete();
    end else if (m_loaded && v) begin
      m_hist.push_back(d);
      if (m_hist.size() > W) void'(m_hist.pop_front());
      if (m_hist.size() == W) begin
        ok = 1;
        for (int i = 0; i < W; i++)
          if (m_msk[W-1-i] && (m_hist[i] != m_pat[W-1-i])) ok = 0;
        if (ok) begin
          e_flag = 1;
          if (!m_ov) m_hist.delete();
        end
      end
    end
    if (clr) m_cnt = 0;
    else if (e_flag && m_cnt < CMAX) m_cnt++;
    e_armed = m_loaded && (m_hist.size() == W);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] stream;
    logic [6:0]  bits7, fon, aon, foff;
    int          con[7];
    int          coff[7];

    drive(0, 0, 0, '0, '0, 0, 0);
    check3("reset", 0, 0, 0);
    rst_n = 1'b1;

    // IDLE ignores the stream until a load.
    for (int i = 0; i < 5; i++) step("idle", 1, 1, 0, '0, '0, 0, 0, 0, 0, 0);

    // Stream match: exactly one hit after the 8th bit.
    stream = 16'b0001_1101_0100_0110;
    add(1, 1, 1, 4'b1101, 4'b1111, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      add(stream[15-i], 1, 0, '0, '0, 0, 0, (i == 7), (i >= 3), (i >= 7) ? 1 : 0);

    // Overlap on / off with stream 1101101.
    bits7 = 7'b1101101;
    fon   = 7'b0001001;
    aon   = 7'b0001111;
    foff  = 7'b0001000;
    con   = '{0, 0, 0, 1, 1, 1, 2};
    coff  = '{0, 0, 0, 1, 1, 1, 1};
    add(0, 1, 1, 4'b1101, 4'b1111, 1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(bits7[6-i], 1, 0, '0, '0, 0, 0, fon[6-i], aon[6-i], con[i]);
    add(0, 1, 1, 4'b1101, 4'b1111, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(bits7[6-i], 1, 0, '0, '0, 0, 0, foff[6-i], 0, coff[i]);

    // Don't-care bits with valid gaps; gap data would break the match if shifted.
    add(0, 1, 1, 4'b1001, 4'b1001, 1, 1, 0, 0, 0);
    add(1, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    add(1, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    add(0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
    add(0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
    add(0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
    add(1, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    add(1, 1, 0, '0, '0, 0, 0, 1, 1, 1);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].din, vecs[i].vld, vecs[i].load, vecs[i].pat,
           vecs[i].msk, vecs[i].ov, vecs[i].clr, vecs[i].flag, vecs[i].armed, vecs[i].cnt);

    // Mid-stream reload: partial 1101 is discarded, 0110 found after 5 bits.
    step("rl_load1", 0, 1, 1, 4'b1101, 4'b1111, 1, 1, 0, 0, 0);
    step("rl_a", 1, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    step("rl_b", 1, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    step("rl_c", 0, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    step("rl_load2", 1, 1, 1, 4'b0110, 4'b1111, 1, 0, 0, 0, 0);
    step("rl_1", 1, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    step("rl_2", 0, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    step("rl_3", 1, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    step("rl_4", 1, 1, 0, '0, '0, 0, 0, 0, 1, 0);
    step("rl_5", 0, 1, 0, '0, '0, 0, 0, 1, 1, 1);

    // Saturation at 3, then clear beats a simultaneous match.
    step("sat_load", 0, 1, 1, 4'b1111, 4'b1111, 1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      step($sformatf("sat%0d", i), 1, 1, 0, '0, '0, 0, 0, (i >= 3), (i >= 3),
           (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
    step("sat_clr", 1, 1, 0, '0, '0, 0, 1, 1, 1, 0);
    step("sat_after", 1, 1, 0, '0, '0, 0, 0, 1, 1, 1);

    // Async reset between edges while flag is high.
    #2;
    rst_n = 1'b0;
    #1;
    check3("async_rst", 0, 0, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("post_rst", 1, 1, 0, '0, '0, 0, 0, 0, 0, 0);
    step("post_load", 0, 1, 1, 4'b1111, 4'b1111, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("post_run", 1, 1, 0, '0, '0, 0, 0, (i == 3), (i == 3), (i == 3) ? 1 : 0);

    // Randomised stimulus against the reference model.
    rst_n = 1'b0;
    drive(0, 0, 0, '0, '0, 0, 0);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 600; k++) begin
      bit           d, v, ld, ov, clr;
      logic [W-1:0] p, m;
      d   = 1'($urandom);
      v   = ($urandom_range(3) != 0);
      ld  = (k == 0) || ($urandom_range(23) == 0);
      p   = W'($urandom);
      m   = ($urandom_range(4) == 0) ? '0 : W'($urandom);
      ov  = 1'($urandom);
      clr = ($urandom_range(39) == 0);
      model_step(d, v, ld, p, m, ov, clr);
      drive(d, v, ld, p, m, ov, clr);
      check3($sformatf("rnd%0d", k), e_flag, e_armed, m_cnt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
